infer_seq_ctrl: RTL and testbench
=================================

# infer_seq_ctrl

Sequencer that owns the serial pixel input of the MNIST inference core. It fetches binarized images word-wide from an image RAM, serializes each image onto the core's 1-bit input as one gapless 784-cycle burst, and waits for the core's result. It then checks the result against a label RAM, accumulates a hit count and advances through a run of images. It sits between the on-chip image/label buffers and `top`, replacing bench-driven streaming in the hardware build.

## Interface
- IMG_PIXELS, 784, pixels per image; must be a multiple of WORD_W.
- WORD_W, 16, image RAM word width; must be ≥2. Pixel 0 of a word is in the MSB.
- ADDR_W, 16, image RAM address width.
- TIMEOUT_CYC, 4096, maximum WAIT_RES cycles. Used only with INFER_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  run request. Sampled only in IDLE.
- img_count  in  10  number of images in the run. Sampled with start.
- mem_rd_en  out  1  image RAM read strobe.
- mem_addr  out  ADDR_W  image RAM word address.
- mem_rdata  in  WORD_W  image RAM data. Valid 1 cycle after the read strobe.
- lbl_addr  out  10  label RAM address. Always equals img_idx.
- lbl_rdata  in  4  label. Valid 1 cycle after lbl_addr changes.
- core_data  out  1  serial pixel to core `data_in`.
- core_valid  in  1  core result strobe.
- core_pred  in  4  core prediction.
- core_conf  in  8  core confidence.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  1-cycle pulse at the end of a run.
- img_idx  out  10  index of the current image.
- hit_count  out  10  number of correct predictions in the run.
- res_valid  out  1  1-cycle per-image result pulse.
- res_pred  out  4  latched prediction.
- res_label  out  4  latched label.
- res_conf  out  8  latched confidence.
- res_hit  out  1  res_pred equals res_label.
- timeout_err  out  1  sticky per run.

## Operation
- States: IDLE, PREFETCH, STREAM, WAIT_RES.
- IDLE:
  - start with img_count≠0: clear hit_count, img_idx, word address and timeout_err; go to PREFETCH.
  - start with img_count=0: pulse done, stay in IDLE.
- PREFETCH (1 cycle): mem_rd_en=1, mem_addr = current word address. Next edge: load shift register from mem_rdata, latch lbl_rdata into the label register, go to STREAM.
- STREAM: core_data = shift register MSB, shifting 1 bit per cycle for IMG_PIXELS cycles.
  - At bit position WORD_W−2 within a word (if words remain in the image), issue the next read.
  - Reload the shift register at position WORD_W−1 so there are no gaps.
  - Word address increments per read. It runs continuously across images, with no multiply (image n base = n·IMG_PIXELS/WORD_W).
  - After the last pixel, go to WAIT_RES.
- WAIT_RES: on core_valid, latch pred/conf, set res_hit, pulse res_valid, and increment hit_count if hit.
  - If img_idx = img_count−1: pulse done, go to IDLE.
  - Otherwise: increment img_idx, go to PREFETCH.
- core_valid outside WAIT_RES is ignored.
- start while busy is ignored.
- core_data=0 and mem_rd_en=0 outside STREAM/PREFETCH.
- Counters are 10-bit. img_count ≤1000 by contract, so hit_count cannot wrap.

## Timing
- Reset: every output and register is 0 and the state is IDLE. A reset in mid-run aborts immediately, with no done pulse. The core's own rst_n is driven from the same reset.
- start sampled at edge k → first pixel on core_data from edge k+2, with 784 consecutive pixels.
- Back-to-back images: core_valid at edge j → next image's first pixel from edge j+2.
- res_valid and the hit_count update occur at the edge after core_valid is sampled. done coincides with the last res_valid.
- Result outputs (res_*) hold their values until the next res_valid.
- hit_count and img_idx hold their values after done until the next start.

## Configuration
- INFER_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_RES.
  - On reaching TIMEOUT_CYC without core_valid: set timeout_err, pulse res_valid with res_pred=4'hF, res_conf=0, res_hit=0, and advance exactly as for a real result.
- Not defined: WAIT_RES waits indefinitely, and timeout_err is tied to 0.

## Structure
- Package infer_pkg holds:
  - IMG_PIXELS, WORD_W and WORDS_PER_IMG (=IMG_PIXELS/WORD_W).
  - The state enum (IDLE, PREFETCH, STREAM, WAIT_RES).
  - The timeout sentinel 4'hF.
- Sub-module px_serializer: WORD_W shift register plus bit/word counters. It exposes load, shift, req_next and last_pixel. The FSM, address, label and scoring logic stay in infer_seq_ctrl.

## Test plan
- Reset then start, img_count=1, RAM word0=16'h8001 → core_data reads 1,0×14,1 from edge k+2. Exactly 49 reads on addresses 0..48, and mem_rd_en never asserts twice in one cycle.
- 3 images with labels 7,2,1; core model returns 7,3,1 → res_hit=1,0,1; hit_count=2; done pulses once with the 3rd res_valid. The 2nd image reads from address 49.
- Core model asserts core_valid 1 cycle after the last pixel → next image's first pixel 2 cycles later. No gap cycles appear inside any 784-pixel burst.
- start with img_count=0 → done pulses the next cycle, busy stays 0. start pulsed during STREAM → no effect.
- rst_n low at pixel 400 of image 5 → all outputs 0 next edge, state IDLE, no done. A fresh start restarts at address 0.
- With INFER_TIMEOUT_EN, core silent → after 4096 WAIT_RES cycles: timeout_err=1, res_pred=4'hF, res_hit=0, and the run continues to the next image.

Source files
------------

// File: rtl/infer_pkg.sv
// Shared constants and state encoding for the MNIST inference sequencer.
package infer_pkg;

  localparam int IMG_PIXELS    = 784;
  localparam int WORD_W        = 16;
  localparam int WORDS_PER_IMG = IMG_PIXELS / WORD_W;

  // Prediction reported when the core never answers.
  localparam logic [3:0] PRED_TIMEOUT = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    STREAM,
    WAIT_RES
  } state_t;

endpackage

// File: rtl/px_serializer.sv
// Word-to-bit serializer: shifts one image out MSB first, asks for the next
// word two pixels before a word ends and reloads on the final pixel.
module px_serializer #(
  parameter int WORD_W  = infer_pkg::WORD_W,
  parameter int N_WORDS = infer_pkg::WORDS_PER_IMG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              dout,
  output logic              req_next,
  output logic              last_pixel
);

  localparam int BW = $clog2(WORD_W);
  localparam int CW = $clog2(N_WORDS + 1);

  logic [WORD_W-1:0] sr;
  logic [BW-1:0]     bit_cnt;
  logic [CW-1:0]     word_cnt;
  logic              active;
  logic              word_end;
  logic              last_word;

  assign word_end   = (bit_cnt == BW'(WORD_W - 1));
  assign last_word  = (word_cnt == CW'(N_WORDS - 1));
  assign dout       = active & sr[WORD_W-1];
  assign req_next   = active & (bit_cnt == BW'(WORD_W - 2)) & ~last_word;
  assign last_pixel = active & word_end & last_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr       <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      active   <= 1'b0;
    end else if (load) begin
      sr       <= din;
      bit_cnt  <= '0;
      word_cnt <= '0;
      active   <= 1'b1;
    end else if (shift && active) begin
      if (word_end) begin
        bit_cnt <= '0;
        if (last_word) begin
          active <= 1'b0;
          sr     <= '0;
        end else begin
          // Word requested at WORD_W-2 is on din now, so no gap cycle.
          sr       <= din;
          word_cnt <= word_cnt + 1'b1;
        end
      end else begin
        sr      <= {sr[WORD_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/infer_seq_ctrl.sv
// Image sequencer for the MNIST core: fetch, serialize, score, advance.
// Optional WAIT_RES watchdog compiled in with `define INFER_TIMEOUT_EN.
module infer_seq_ctrl #(
  parameter int IMG_PIXELS  = infer_pkg::IMG_PIXELS,
  parameter int WORD_W      = infer_pkg::WORD_W,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [9:0]        img_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [9:0]        lbl_addr,
  input  logic [3:0]        lbl_rdata,
  output logic              core_data,
  input  logic              core_valid,
  input  logic [3:0]        core_pred,
  input  logic [7:0]        core_conf,
  output logic              busy,
  output logic              done,
  output logic [9:0]        img_idx,
  output logic [9:0]        hit_count,
  output logic              res_valid,
  output logic [3:0]        res_pred,
  output logic [3:0]        res_label,
  output logic [7:0]        res_conf,
  output logic              res_hit,
  output logic              timeout_err
);

  import infer_pkg::*;

  localparam int N_WORDS = IMG_PIXELS / WORD_W;

  state_t            state;
  logic [ADDR_W-1:0] waddr;
  logic [9:0]        run_len;
  logic [3:0]        lbl_q;
  logic              load_pend;
  logic              ser_shift;
  logic              req_next;
  logic              last_pixel;
  logic              last_img;
  logic              timeout_hit;
  logic              res_event;
  logic              hit_now;
  logic [3:0]        pred_now;
  logic [7:0]        conf_now;

  px_serializer #(
    .WORD_W  (WORD_W),
    .N_WORDS (N_WORDS)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_pend),
    .shift      (ser_shift),
    .din        (mem_rdata),
    .dout       (core_data),
    .req_next   (req_next),
    .last_pixel (last_pixel)
  );

  assign ser_shift = (state == STREAM);
  assign mem_rd_en = (state == PREFETCH) | req_next;
  assign mem_addr  = waddr;
  assign lbl_addr  = img_idx;
  assign busy      = (state != IDLE);
  assign last_img  = (img_idx == run_len - 10'd1);

  always_comb begin
    res_event = 1'b0;
    hit_now   = 1'b0;
    pred_now  = core_pred;
    conf_now  = core_conf;
    if (state == WAIT_RES) begin
      if (core_valid) begin
        res_event = 1'b1;
        hit_now   = (core_pred == lbl_q);
      end else if (timeout_hit) begin
        res_event = 1'b1;
        pred_now  = PRED_TIMEOUT;
        conf_now  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      waddr     <= '0;
      run_len   <= '0;
      img_idx   <= '0;
      hit_count <= '0;
      lbl_q     <= '0;
      load_pend <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_pred  <= '0;
      res_label <= '0;
      res_conf  <= '0;
      res_hit   <= 1'b0;
    end else begin
      done      <= 1'b0;
      res_valid <= 1'b0;
      load_pend <= 1'b0;
      // The word address never rewinds between images of a run.
      if (mem_rd_en) waddr <= waddr + 1'b1;
      if (load_pend) lbl_q <= lbl_rdata;
      case (state)
        IDLE: begin
          if (start) begin
            if (img_count == '0) begin
              done <= 1'b1;
            end else begin
              run_len   <= img_count;
              img_idx   <= '0;
              hit_count <= '0;
              waddr     <= '0;
              state     <= PREFETCH;
            end
          end
        end
        PREFETCH: begin
          load_pend <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (last_pixel) state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (res_event) begin
            res_valid <= 1'b1;
            res_pred  <= pred_now;
            res_conf  <= conf_now;
            res_label <= lbl_q;
            res_hit   <= hit_now;
            if (hit_now) hit_count <= hit_count + 10'd1;
            if (last_img) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              img_idx <= img_idx + 10'd1;
              state   <= PREFETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wait_cnt;
  logic          tmo_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT_RES) ? wait_cnt + 1'b1 : '0;
      if (state == IDLE && start && img_count != '0) tmo_q <= 1'b0;
      else if (state == WAIT_RES && !core_valid && timeout_hit) tmo_q <= 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt == TW'(TIMEOUT_CYC - 1));
  assign timeout_err = tmo_q;
`else
  // Without the watchdog WAIT_RES only ends on a core result.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_infer_seq_ctrl.sv
// Scoreboard bench for infer_seq_ctrl: directed runs, pixel bursts checked
// against the image RAM model, per-image results checked by a monitor.
`timescale 1ns/1ps
module tb_infer_seq_ctrl;

  localparam int IMG_PIXELS  = 784;
  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int TIMEOUT_CYC = 4096;
  localparam int N_WORDS     = IMG_PIXELS / WORD_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [9:0]        img_count;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic [9:0]        lbl_addr;
  logic [3:0]        lbl_rdata;
  logic              core_data;
  logic              core_valid;
  logic [3:0]        core_pred;
  logic [7:0]        core_conf;
  logic              busy;
  logic              done;
  logic [9:0]        img_idx;
  logic [9:0]        hit_count;
  logic              res_valid;
  logic [3:0]        res_pred;
  logic [3:0]        res_label;
  logic [7:0]        res_conf;
  logic              res_hit;
  logic              timeout_err;

  infer_seq_ctrl #(
    .IMG_PIXELS  (IMG_PIXELS),
    .WORD_W      (WORD_W),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .img_count   (img_count),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .lbl_addr    (lbl_addr),
    .lbl_rdata   (lbl_rdata),
    .core_data   (core_data),
    .core_valid  (core_valid),
    .core_pred   (core_pred),
    .core_conf   (core_conf),
    .busy        (busy),
    .done        (done),
    .img_idx     (img_idx),
    .hit_count   (hit_count),
    .res_valid   (res_valid),
    .res_pred    (res_pred),
    .res_label   (res_label),
    .res_conf    (res_conf),
    .res_hit     (res_hit),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous image and label RAMs: data one cycle after the request.
  logic [15:0] ram [0:511];
  logic [3:0]  lbl_ram [0:15];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr[8:0]];
    lbl_rdata <= lbl_ram[lbl_addr[3:0]];
  end

  typedef struct packed {
    logic [3:0] pred;
    logic [3:0] label;
    logic [7:0] conf;
    logic       hit;
    logic [9:0] hc;
    logic       done;
  } res_t;

  res_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          addr_err = 0;
  int          exp_addr = 0;
  int          res_seen = 0;
  logic [15:0] first_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] pred, input logic [3:0] label, input logic [7:0] conf,
                          input logic hit, input logic [9:0] hc, input logic dn);
    res_t e;
    e.pred  = pred;
    e.label = label;
    e.conf  = conf;
    e.hit   = hit;
    e.hc    = hc;
    e.done  = dn;
    exp_q.push_back(e);
  endtask

  // Monitor: read-address tracking and result scoreboard.
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (mem_rd_en) begin
      rd_cnt++;
      if (mem_addr != exp_addr[ADDR_W-1:0]) addr_err++;
      exp_addr++;
    end
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", 64'd1, 64'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check($sformatf("res%0d", res_seen),
              {res_pred, res_label, res_conf, res_hit, hit_count, done}, e);
      end
      res_seen++;
    end
  end

  function automatic logic exp_px(input int base, input int i);
    logic [15:0] w;
    w = ram[base + i / WORD_W];
    return w[WORD_W - 1 - (i % WORD_W)];
  endfunction

  // Enter and leave at the negedge right after the accepting edge.
  task automatic start_run(input logic [9:0] n);
    exp_addr  = 0;
    rd_cnt    = 0;
    start     = 1'b1;
    img_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Core model for one image: checks the burst, then answers or stays silent.
  task automatic run_image(input int img, input int base, input logic [3:0] pred,
                           input logic [7:0] conf, input bit silent,
                           input int abort_at, input int poke_at);
    int bad;
    int n;
    check($sformatf("prefetch_addr%0d", img), {mem_rd_en, mem_addr}, {1'b1, 16'(base)});
    @(posedge clk);
    @(posedge clk);
    bad = 0;
    for (int i = 0; i < IMG_PIXELS; i++) begin
      @(negedge clk);
      if (core_data !== exp_px(base, i)) bad++;
      if (i < 16) first_word[15 - i] = core_data;
      if (i == poke_at) begin
        start     = 1'b1;
        img_count = 10'd5;
      end else begin
        start = 1'b0;
      end
      if (i == abort_at) begin
        rst_n = 1'b0;
        check($sformatf("burst_prefix%0d", img), bad, 0);
        return;
      end
    end
    start = 1'b0;
    check($sformatf("burst%0d", img), bad, 0);
    @(negedge clk);
    check($sformatf("idle_data%0d", img), core_data, 1'b0);
    if (!silent) begin
      core_valid = 1'b1;
      core_pred  = pred;
      core_conf  = conf;
      @(negedge clk);
      core_valid = 1'b0;
    end else begin
      n = 0;
      while (!res_valid && n < TIMEOUT_CYC + 100) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("timeout_wait%0d", img), n, TIMEOUT_CYC);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, res_valid, mem_rd_en, core_data, timeout_err, res_hit}, 0);
    check({tag, "_dat"}, {res_pred, res_label, res_conf, img_idx, hit_count, mem_addr, lbl_addr}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 512; a++) ram[a] = 16'((a * 40503) ^ (a << 3) ^ 16'h3C5A);
    ram[0] = 16'h8001;
    for (int a = 0; a < 16; a++) lbl_ram[a] = 4'd0;
    lbl_ram[0] = 4'd7; lbl_ram[1] = 4'd2; lbl_ram[2] = 4'd1;
    lbl_ram[3] = 4'd0; lbl_ram[4] = 4'd4; lbl_ram[5] = 4'd9;

    rst_n      = 1'b0;
    start      = 1'b0;
    img_count  = '0;
    core_valid = 1'b0;
    core_pred  = '0;
    core_conf  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single image, first word 16'h8001, label 7, correct prediction.
    push_exp(4'd7, 4'd7, 8'h55, 1'b1, 10'd1, 1'b1);
    start_run(10'd1);
    run_image(0, 0, 4'd7, 8'h55, 1'b0, -1, -1);
    @(negedge clk);
    check("first_word", first_word, 16'h8001);
    check("reads_one", rd_cnt, 49);
    check("addr_one", addr_err, 0);
    check("done_one", done_cnt, 1);
    check("busy_after_one", busy, 1'b0);

    // Three images, labels 7,2,1, predictions 7,3,1; start poked mid-stream.
    push_exp(4'd7, 4'd7, 8'h80, 1'b1, 10'd1, 1'b0);
    push_exp(4'd3, 4'd2, 8'h40, 1'b0, 10'd1, 1'b0);
    push_exp(4'd1, 4'd1, 8'hC0, 1'b1, 10'd2, 1'b1);
    start_run(10'd3);
    run_image(0, 0,  4'd7, 8'h80, 1'b0, -1, -1);
    run_image(1, 49, 4'd3, 8'h40, 1'b0, -1, 300);
    run_image(2, 98, 4'd1, 8'hC0, 1'b0, -1, -1);
    @(negedge clk);
    check("reads_three", rd_cnt, 147);
    check("addr_three", addr_err, 0);
    check("done_three", done_cnt, 2);
    check("hits_three", hit_count, 10'd2);
    check("busy_after_three", busy, 1'b0);

    // Empty run: done pulse only, never busy.
    start     = 1'b1;
    img_count = 10'd0;
    @(negedge clk);
    start = 1'b0;
    check("empty_pulse", {done, busy}, 2'b10);
    @(negedge clk);
    check("empty_after", {done, busy}, 2'b00);
    check("done_empty", done_cnt, 3);
    check("hits_held", hit_count, 10'd2);

    // Six images, reset lands at pixel 400 of image 5.
    push_exp(4'd7, 4'd7, 8'h00, 1'b1, 10'd1, 1'b0);
    push_exp(4'd2, 4'd2, 8'h10, 1'b1, 10'd2, 1'b0);
    push_exp(4'd0, 4'd1, 8'h20, 1'b0, 10'd2, 1'b0);
    push_exp(4'd0, 4'd0, 8'h30, 1'b1, 10'd3, 1'b0);
    push_exp(4'd4, 4'd4, 8'h40, 1'b1, 10'd4, 1'b0);
    start_run(10'd6);
    run_image(0, 0,   4'd7, 8'h00, 1'b0, -1, -1);
    run_image(1, 49,  4'd2, 8'h10, 1'b0, -1, -1);
    run_image(2, 98,  4'd0, 8'h20, 1'b0, -1, -1);
    run_image(3, 147, 4'd0, 8'h30, 1'b0, -1, -1);
    run_image(4, 196, 4'd4, 8'h40, 1'b0, -1, -1);
    run_image(5, 245, 4'd0, 8'h00, 1'b0, 400, -1);
    @(negedge clk);
    check_all_zero("abort");
    check("abort_no_done", done_cnt, 3);
    check("abort_queue", exp_q.size(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh run after the abort restarts at address 0; wrong prediction.
    push_exp(4'd5, 4'd7, 8'h99, 1'b0, 10'd0, 1'b1);
    start_run(10'd1);
    run_image(0, 0, 4'd5, 8'h99, 1'b0, -1, -1);
    @(negedge clk);
    check("reads_fresh", rd_cnt, 49);
    check("addr_fresh", addr_err, 0);
    check("done_fresh", done_cnt, 4);

`ifdef INFER_TIMEOUT_EN
    // Silent core on image 0, normal answer on image 1.
    push_exp(4'hF, 4'd7, 8'h00, 1'b0, 10'd0, 1'b0);
    push_exp(4'd2, 4'd2, 8'h33, 1'b1, 10'd1, 1'b1);
    start_run(10'd2);
    run_image(0, 0, 4'd0, 8'h00, 1'b1, -1, -1);
    check("timeout_flag", timeout_err, 1'b1);
    run_image(1, 49, 4'd2, 8'h33, 1'b0, -1, -1);
    @(negedge clk);
    check("timeout_sticky", timeout_err, 1'b1);
    check("done_timeout", done_cnt, 5);
`else
    check("timeout_tied", timeout_err, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
